// File: rtl/chunked_adder_pkg.sv
// Shared types for the chunked multi-cycle adder.
// Holds the FSM state enum and the WIDTH/CHUNK legality check.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  function automatic bit width_ok(int width, int chunk);
    return (chunk > 0) && (width >= chunk) &&
           ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/chunked_adder_if.sv
// Valid/ready operand and result bundle for chunked_adder.
// master = producer/consumer side, slave = the adder.
// Define CHUNKED_ADDER_SUB_EN to add the sub select.
interface chunked_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef CHUNKED_ADDER_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carryout;
  logic             overflow;

  modport master (
`ifdef CHUNKED_ADDER_SUB_EN
    output sub,
`endif
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum,
    input  carryout, overflow
  );

  modport slave (
`ifdef CHUNKED_ADDER_SUB_EN
    input  sub,
`endif
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum,
    output carryout, overflow
  );

endinterface

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple adder slice.
// Ports: a, b, ci in; s, co, cm (carry into MSB) out.
module chunk_adder #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             cm
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) |
               (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co = c[CHUNK];
  assign cm = c[CHUNK-1];

endmodule

// File: rtl/chunked_adder.sv
// Multi-cycle adder: CHUNK bits per clock, carry held in a flop.
// Ports: clk, rst_n (async low), bus (chunked_adder_if.slave).
// Define CHUNKED_ADDER_SUB_EN to enable a-b via bus.sub.
module chunked_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  chunked_adder_if.slave  bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NCHUNK - 1);

  if (!width_ok(WIDTH, CHUNK)) begin : g_bad_width
    $error("chunked_adder: WIDTH must be a multiple of CHUNK");
  end

  state_e           state_q;
  state_e           state_d;
  logic [KW-1:0]    k_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             cy_q;
  logic             co_q;
  logic             ov_q;

  logic [CHUNK-1:0] ca;
  logic [CHUNK-1:0] cb;
  logic [CHUNK-1:0] cs;
  logic             cc;
  logic             cm;
  logic             acc;
  logic             last;

  assign acc  = (state_q == IDLE) && bus.in_valid;
  assign last = (k_q == KLAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid)  state_d = RUN;
      RUN:     if (last)          state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // one adder slice, fed by the chunk selected by k
  always_comb begin
    ca = '0;
    cb = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (k_q == KW'(i)) begin
        ca = a_q[i*CHUNK +: CHUNK];
        cb = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a  (ca),
    .b  (cb),
    .ci (cy_q),
    .s  (cs),
    .co (cc),
    .cm (cm)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
      cy_q  <= 1'b0;
      co_q  <= 1'b0;
      ov_q  <= 1'b0;
    end else if (acc) begin
      a_q <= bus.a;
      k_q <= '0;
`ifdef CHUNKED_ADDER_SUB_EN
      // a-b == a + ~b + 1
      b_q  <= bus.sub ? ~bus.b : bus.b;
      cy_q <= bus.sub | bus.cin;
`else
      b_q  <= bus.b;
      cy_q <= bus.cin;
`endif
    end else if (state_q == RUN) begin
      for (int i = 0; i < NCHUNK; i++) begin
        if (k_q == KW'(i))
          sum_q[i*CHUNK +: CHUNK] <= cs;
      end
      cy_q <= cc;
      k_q  <= k_q + KW'(1);
      if (last) begin
        co_q <= cc;
        ov_q <= cm ^ cc;
      end
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.carryout  = co_q;
  assign bus.overflow  = ov_q;

endmodule

// File: tb/tb_chunked_adder.sv
// Scoreboard bench for chunked_adder: 8/4 and 32/8 instances.
// Random and directed ops checked against an integer model.
module tb_chunked_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  chunked_adder_if #(.WIDTH(8))  b8 ();
  chunked_adder_if #(.WIDTH(32)) b32 ();

  chunked_adder #(.WIDTH(8), .CHUNK(4)) u8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b8.slave)
  );

  chunked_adder #(.WIDTH(32), .CHUNK(8)) u32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b32.slave)
  );

  typedef struct packed {
    logic        co;
    logic        ov;
    logic [31:0] s;
  } exp_t;

  exp_t q8[$];
  exp_t q32[$];
  exp_t e8;
  exp_t e32;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  // reference: signed/unsigned integer arithmetic, mod 2^w
  function automatic exp_t model(int w, logic [31:0] a,
                                 logic [31:0] b, logic cin,
                                 logic sub);
    longint m, ua, ub, sa, sb, r;
    exp_t e;
    m  = longint'(1) << w;
    ua = longint'({32'h0, a}) & (m - 1);
    ub = longint'({32'h0, b}) & (m - 1);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    if (sub) begin
      r    = sa - sb;
      e.co = (ua >= ub);
      e.s  = 32'((ua - ub) & (m - 1));
    end else begin
      r    = sa + sb + longint'(cin);
      e.co = ((ua + ub + longint'(cin)) >= m);
      e.s  = 32'((ua + ub + longint'(cin)) & (m - 1));
    end
    e.ov = (r < -(m / 2)) || (r >= m / 2);
    return e;
  endfunction

  function automatic exp_t res(bit sel);
    if (sel) return {b32.carryout, b32.overflow, b32.sum};
    return {b8.carryout, b8.overflow, 24'h0, b8.sum};
  endfunction

  function automatic logic ir(bit sel);
    return sel ? b32.in_ready : b8.in_ready;
  endfunction

  function automatic logic ov(bit sel);
    return sel ? b32.out_valid : b8.out_valid;
  endfunction

  task automatic drive(input bit sel, input logic v,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic sub);
    if (sel) begin
      b32.in_valid = v;
      b32.a        = a;
      b32.b        = b;
      b32.cin      = cin;
`ifdef CHUNKED_ADDER_SUB_EN
      b32.sub      = sub;
`endif
    end else begin
      b8.in_valid = v;
      b8.a        = a[7:0];
      b8.b        = b[7:0];
      b8.cin      = cin;
`ifdef CHUNKED_ADDER_SUB_EN
      b8.sub      = sub;
`endif
    end
  endtask

  task automatic set_ordy(input bit sel, input logic r);
    if (sel) b32.out_ready = r;
    else     b8.out_ready  = r;
  endtask

  task automatic op(input bit sel, input logic [31:0] a,
                    input logic [31:0] b, input logic cin,
                    input logic sub, input int hold,
                    input bit scr);
    exp_t e;
    int   n;
    logic se;
`ifdef CHUNKED_ADDER_SUB_EN
    se = sub;
`else
    se = 1'b0;
`endif
    e = model(sel ? 32 : 8, a, b, cin, se);
    n = 0;
    while (!ir(sel) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("accept_wait", 64'(n < 50), 1);
    drive(sel, 1'b1, a, b, cin, sub);
    if (sel) q32.push_back(e);
    else     q8.push_back(e);
    @(posedge clk); #1;
    drive(sel, 1'b0, a, b, cin, sub);
    n = 0;
    while (!ov(sel) && n < 20) begin
      chk("in_ready_run", ir(sel), 0);
      if (scr)
        drive(sel, 1'b0, $urandom, $urandom,
              1'($urandom), 1'($urandom));
      @(posedge clk); #1; n++;
    end
    chk("latency", n, sel ? 4 : 2);
    for (int i = 0; i < hold; i++) begin
      chk("hold_result", res(sel), e);
      chk("hold_in_ready", ir(sel), 0);
      @(posedge clk); #1;
      chk("hold_valid", ov(sel), 1);
    end
    set_ordy(sel, 1'b1);
    @(posedge clk); #1;
    set_ordy(sel, 1'b0);
    chk("idle_after", {ir(sel), ov(sel)}, 2'b10);
  endtask

  always @(negedge clk) begin
    if (rst_n && b8.out_valid && b8.out_ready) begin
      if (q8.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb8_pop: got result, want none queued");
      end else begin
        e8 = q8.pop_front();
        chk("result8", res(0), e8);
      end
    end
    if (rst_n && b32.out_valid && b32.out_ready) begin
      if (q32.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb32_pop: got result, want none queued");
      end else begin
        e32 = q32.pop_front();
        chk("result32", res(1), e32);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(0, 1'b0, 0, 0, 1'b0, 1'b0);
    drive(1, 1'b0, 0, 0, 1'b0, 1'b0);
    set_ordy(0, 1'b0);
    set_ordy(1, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hs8", {ir(0), ov(0)}, 2'b10);
    chk("rst_res8", res(0), 0);
    chk("rst_hs32", {ir(1), ov(1)}, 2'b10);
    chk("rst_res32", res(1), 0);
    rst_n = 1'b1;

    op(0, 32'h7F, 32'h01, 1'b0, 1'b0, 0, 0);
    op(0, 32'hFF, 32'hFF, 1'b0, 1'b0, 0, 0);
    op(0, 32'h80, 32'h80, 1'b0, 1'b0, 0, 0);
    op(0, 32'h0F, 32'h00, 1'b1, 1'b0, 0, 0);
`ifdef CHUNKED_ADDER_SUB_EN
    op(0, 32'h00, 32'h01, 1'b1, 1'b1, 0, 0);
    op(0, 32'h80, 32'h01, 1'b0, 1'b1, 0, 0);
`endif
    op(0, 32'h35, 32'h4A, 1'b0, 1'b0, 5, 1);

    // abort mid-RUN with async reset
    drive(0, 1'b1, 32'h12, 32'h34, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, 32'h12, 32'h34, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_hs", {ir(0), ov(0)}, 2'b10);
    chk("midrst_res", res(0), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    op(0, 32'h01, 32'h02, 1'b0, 1'b0, 0, 0);

    op(1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1, 0);
    op(1, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 0, 1);

    for (int i = 0; i < 30; i++)
      op(0, $urandom, $urandom, 1'($urandom), 1'($urandom),
         $urandom_range(0, 2), 1'($urandom));
    for (int i = 0; i < 30; i++)
      op(1, $urandom, $urandom, 1'($urandom), 1'($urandom),
         $urandom_range(0, 2), 1'($urandom));

    repeat (3) @(posedge clk);
    chk("sb8_drained", q8.size(), 0);
    chk("sb32_drained", q32.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
